// File: rtl/uart_mini_rx.sv
// uart_mini_rx -- 8N1 UART receiver with an RX FIFO and an APB slave.
//
// The receiver takes 1 start bit, 8 data bits sent LSB first, and 1 stop bit.
// A per-bit cycle counter times each bit, and the line is sampled at mid-bit.
// Good bytes go into a FIFO of FIFO_DEPTH entries. The CPU reads them over APB.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit (>= 4)
//   FIFO_DEPTH    RX FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst_n                clock / asynchronous active-low reset
//   apbs_psel, apbs_penable,  APB slave inputs; only apbs_paddr[3:2] is decoded
//   apbs_pwrite, apbs_paddr,
//   apbs_pwdata
//   apbs_prdata               APB read data; combinational, zero outside read access
//   apbs_pready, apbs_pslverr tied 1 / 0
//   rx                        serial input (asynchronous, idle high)
//   rts                       flow control, low = ready to receive
//   irq                       registered level interrupt
//   dreq                      DMA request = FIFO not empty
//
// Register map
//   0x0 RXDATA  [7:0] FIFO head. Reading it pops the head. An empty read returns 0.
//   0x4 STATUS  [0] not_empty [1] full [2] overrun (W1C) [3] frame_err (W1C)
//   0x8 CTRL    [0] IRQEN
//   0xC         reads 0
//
// Build option
//   UART_RX_RTS_EN  registered rts goes high when the FIFO count >= FIFO_DEPTH-1.
//                   When the macro is undefined, rts is tied low.

module uart_mini_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        apbs_psel,
  input  logic        apbs_penable,
  input  logic        apbs_pwrite,
  input  logic [15:0] apbs_paddr,
  input  logic [31:0] apbs_pwdata,
  output logic [31:0] apbs_prdata,
  output logic        apbs_pready,
  output logic        apbs_pslverr,
  input  logic        rx,
  output logic        rts,
  output logic        irq,
  output logic        dreq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } state_t;

  // ---------------------------------------------------------------- sync
  logic rx_s1, rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s2) begin
            state <= S_START;
            cnt   <= HALF_LOAD;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            if (rx_s2) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              cnt     <= FULL_LOAD;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            shift[bit_idx] <= rx_s2;
            cnt            <= FULL_LOAD;
            if (bit_idx == 3'd7) state <= S_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == '0) state <= rx_s2 ? S_IDLE : S_WAITHI;
          else           cnt   <= cnt - 1'b1;
        end
        S_WAITHI: begin
          if (rx_s2) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Push and frame_err are decoded in the same cycle as the stop-bit sample.
  // The FIFO write then becomes visible one cycle later.
  logic stop_sample, push_req, fe_set;
  assign stop_sample = (state == S_STOP) && (cnt == '0);
  assign push_req    = stop_sample && rx_s2;
  assign fe_set      = stop_sample && !rx_s2;

  // ---------------------------------------------------------------- APB decode
  logic       rd_acc, wr_acc;
  logic [1:0] sel;
  assign rd_acc = apbs_psel && apbs_penable && !apbs_pwrite;
  assign wr_acc = apbs_psel && apbs_penable &&  apbs_pwrite;
  assign sel    = apbs_paddr[3:2];

  // ---------------------------------------------------------------- FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, do_push, ovr_set;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign pop   = rd_acc && (sel == 2'd0) && !empty;
  // When the FIFO is full, a pop in the same cycle frees a slot for the push.
  assign do_push = push_req && (!full || pop);
  assign ovr_set = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- regs
  logic overrun, frame_err, irqen;
  logic st_wr;
  assign st_wr = wr_acc && (sel == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irqen     <= 1'b0;
      irq       <= 1'b0;
    end else begin
      // If a flag is set and cleared in the same cycle, the set wins.
      overrun   <= ovr_set | (overrun   & ~(st_wr & apbs_pwdata[2]));
      frame_err <= fe_set  | (frame_err & ~(st_wr & apbs_pwdata[3]));
      if (wr_acc && (sel == 2'd2)) irqen <= apbs_pwdata[0];
      irq <= irqen & (!empty | overrun | frame_err);
    end
  end

  always_comb begin
    apbs_prdata = '0;
    if (rd_acc) begin
      case (sel)
        2'd0:    if (!empty) apbs_prdata[7:0] = mem[rd_ptr];
        2'd1:    apbs_prdata[3:0] = {frame_err, overrun, full, !empty};
        2'd2:    apbs_prdata[0]   = irqen;
        default: apbs_prdata = '0;
      endcase
    end
  end

  assign apbs_pready  = 1'b1;
  assign apbs_pslverr = 1'b0;
  assign dreq         = !empty;

`ifdef UART_RX_RTS_EN
  localparam logic [AW:0] RTS_TH = (AW + 1)'(FIFO_DEPTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rts <= 1'b0;
    else        rts <= (count >= RTS_TH);
  end
`else
  assign rts = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{apbs_paddr[15:4], apbs_paddr[1:0], apbs_pwdata[31:4], apbs_pwdata[1]};

endmodule

// File: tb/tb_uart_mini_rx.sv
module tb_uart_mini_rx;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        rx = 1'b1;
  logic        rts, irq, dreq;

  int total = 0;
  int bad   = 0;

  // bench model
  logic [7:0] exp_q[$];
  bit         m_ovr = 0, m_fe = 0;

  uart_mini_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
    .apbs_paddr(paddr), .apbs_pwdata(pwdata), .apbs_prdata(prdata),
    .apbs_pready(pready), .apbs_pslverr(pslverr),
    .rx(rx), .rts(rts), .irq(irq), .dreq(dreq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h required=0x%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {28'd0, m_fe, m_ovr, exp_q.size() == DEPTH, exp_q.size() != 0};
  endfunction

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    @(posedge clk); #1 psel = 1; pwrite = 0; paddr = a;
    @(posedge clk); #1 penable = 1;
    @(negedge clk); d = prdata;
    @(posedge clk); #1 psel = 0; penable = 0;
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1 psel = 1; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
    if (a[3:2] == 2'd1) begin
      if (d[2]) m_ovr = 0;
      if (d[3]) m_fe  = 0;
    end
  endtask

  task automatic bit_out(input logic v);
    @(posedge clk); #1 rx = v;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    if (!stop) repeat (16) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    if (!stop)                      m_fe = 1;
    else if (exp_q.size() < DEPTH)  exp_q.push_back(b);
    else                            m_ovr = 1;
  endtask

  task automatic read_rx(input string nm);
    logic [31:0] d;
    logic [7:0]  e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    apb_read(16'h0, d);
    check(nm, d, {24'd0, e});
  endtask

  task automatic check_status(input string nm);
    logic [31:0] d;
    apb_read(16'h4, d);
    check(nm, d, model_status());
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [3:0] st_rx;
    logic       do_read;
    logic [3:0] clr;
    logic [3:0] st_end;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] d;

    vecs[0] = '{8'hA5, 1'b1, 4'h1, 1'b1, 4'h0, 4'h0};
    vecs[1] = '{8'h3C, 1'b0, 4'h8, 1'b0, 4'h8, 4'h0};
    vecs[2] = '{8'h5A, 1'b1, 4'h1, 1'b1, 4'h0, 4'h0};
    vecs[3] = '{8'h00, 1'b1, 4'h1, 1'b1, 4'h0, 4'h0};
    vecs[4] = '{8'hFF, 1'b1, 4'h1, 1'b1, 4'h0, 4'h0};
    vecs[5] = '{8'h80, 1'b0, 4'h8, 1'b1, 4'h8, 4'h0};

    // reset state
    #23;
    check("rst_prdata", prdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_dreq", {31'd0, dreq}, 32'h0);
    check("rst_rts", {31'd0, rts}, 32'h0);
    rst_n = 1'b1;
    check("pready", {31'd0, pready}, 32'h1);
    check("pslverr", {31'd0, pslverr}, 32'h0);
    apb_read(16'h4, d); check("rst_status", d, 32'h0);
    apb_read(16'h8, d); check("rst_ctrl", d, 32'h0);
    apb_write(16'hC, 32'hFFFF_FFFF);
    apb_read(16'hC, d); check("reg_c", d, 32'h0);
    apb_read(16'h0, d); check("empty_rxdata", d, 32'h0);

    // table-driven frames
    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].stop);
      apb_read(16'h4, d);
      check($sformatf("v%0d_status", k), d, {28'd0, vecs[k].st_rx});
      check($sformatf("v%0d_model", k), d, model_status());
      check($sformatf("v%0d_dreq", k), {31'd0, dreq}, {31'd0, vecs[k].st_rx[0]});
      if (vecs[k].do_read) read_rx($sformatf("v%0d_rxdata", k));
      if (vecs[k].clr != 4'h0) apb_write(16'h4, {28'd0, vecs[k].clr});
      apb_read(16'h4, d);
      check($sformatf("v%0d_status_end", k), d, {28'd0, vecs[k].st_end});
    end

    // short start glitch must not start a frame
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (12) @(posedge clk);
    apb_read(16'h4, d); check("glitch_status", d, 32'h0);

    // overrun: five bytes into a four-entry FIFO
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    apb_read(16'h4, d); check("ovr_status", d, 32'h7);
    for (int i = 0; i < 5; i++) read_rx($sformatf("ovr_rd%0d", i));
    check_status("ovr_after_reads");
    apb_write(16'h4, 32'h4);
    apb_read(16'h4, d); check("ovr_cleared", d, 32'h0);

    // interrupt on data, registered release after pop
    apb_write(16'h8, 32'h1);
    apb_read(16'h8, d); check("ctrl_rb", d, 32'h1);
    check("irq_idle", {31'd0, irq}, 32'h0);
    send_frame(8'h55, 1'b1);
    check("irq_set", {31'd0, irq}, 32'h1);
    read_rx("irq_rxdata");
    check("dreq_after_pop", {31'd0, dreq}, 32'h0);
    check("irq_hold", {31'd0, irq}, 32'h1);
    @(posedge clk); #1;
    check("irq_clear", {31'd0, irq}, 32'h0);
    apb_write(16'h8, 32'h0);

    // reset in the middle of data bit 4
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete(); m_ovr = 0; m_fe = 0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1; rst_n = 1'b1;
    repeat (6) @(posedge clk);
    apb_read(16'h4, d); check("midrst_status", d, 32'h0);
    send_frame(8'h81, 1'b1);
    apb_read(16'h4, d); check("midrst_rx_status", d, 32'h1);
    read_rx("midrst_rxdata");
    check_status("midrst_end");

    // flow control threshold
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
`ifdef UART_RX_RTS_EN
    check("rts_high", {31'd0, rts}, 32'h1);
`else
    check("rts_high", {31'd0, rts}, 32'h0);
`endif
    read_rx("rts_rd0");
    @(posedge clk); #1;
    check("rts_low", {31'd0, rts}, 32'h0);
    read_rx("rts_rd1");
    read_rx("rts_rd2");
    check_status("final_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
